baud_ctrl: RTL

BAUD_CTRL -- requirements
Module: baud_ctrl

---
 rtl/baud_pkg.sv | 20 ++
 rtl/baud_prescale.sv | 84 ++++++++
 rtl/baud_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared constants and state encoding for the baud-rate controller.
//   DIV_W       : prescale divisor width
//   OVS         : oversample ticks per bit period
//   DEFAULT_DIV : divisor loaded at reset (50 MHz, 9600 baud, x16)
//   FRAC_W      : fractional divisor width (sixteenths)
//   state_e     : controller states
package baud_pkg;

    localparam int unsigned DIV_W       = 16;
    localparam int unsigned OVS         = 16;
    localparam int unsigned DEFAULT_DIV = 326;
    localparam int unsigned FRAC_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

endpackage

// File: rtl/baud_prescale.sv
// Prescale counter: counts 0..last and flags the wrap cycle. With
// BAUD_CTRL_FRAC_EN defined, a 4-bit phase accumulator adds frac_i on every
// wrap and a carry-out stretches the following period by one cycle.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   run_i      : count enable; low holds everything at zero
//   clr_i      : phase restart; zeroes the count and masks the wrap
//   div_i      : active divisor (>= 2)
//   frac_i     : active fractional divisor (ignored without BAUD_CTRL_FRAC_EN)
//   wrap_c_o   : combinational, high in the cycle the count sits at its last value
module baud_prescale #(
    parameter int unsigned DIV_W = baud_pkg::DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [3:0]       frac_i,
    output logic             wrap_c_o
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic [DIV_W-1:0] last_c;

`ifdef BAUD_CTRL_FRAC_EN
    logic [3:0] acc_q;
    logic [3:0] acc_d;
    logic       stretch_q;
    logic       stretch_d;
    logic [4:0] sum_c;

    // A stretched period ends one count later.
    assign last_c = stretch_q ? div_i : div_i - DIV_W'(1);
    assign sum_c  = 5'(acc_q) + 5'(frac_i);

    // Phase accumulator; its carry decides the length of the next period.
    always_comb begin
        acc_d     = acc_q;
        stretch_d = stretch_q;
        if (!run_i || clr_i) begin
            acc_d     = '0;
            stretch_d = 1'b0;
        end else if (wrap_c_o) begin
            acc_d     = sum_c[3:0];
            stretch_d = sum_c[4];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^frac_i;
    assign last_c      = div_i - DIV_W'(1);
`endif

    assign wrap_c_o = run_i && !clr_i && (count_q == last_c);

    // Count up, restarting at zero on wrap, phase restart or halt.
    always_comb begin
        count_d = count_q + DIV_W'(1);
        if (!run_i || clr_i || wrap_c_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/baud_ctrl.sv
// Baud-rate controller: prescaler-driven oversample and bit ticks with a
// glitch-free, wrap-aligned divisor update path.
// Optional feature: define BAUD_CTRL_FRAC_EN for fractional division.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : run request; low halts and zeroes all counters
//   div_wr     : one-cycle divisor update strobe
//   div_val    : new divisor (0 and 1 clamp to 2)
//   div_frac   : new fractional divisor in sixteenths
//   phase_clr  : restart bit phase
//   div_ack    : pulse when a written divisor takes effect
//   tick_ovs   : oversample tick
//   tick_bit   : bit tick, coincident with every OVS-th oversample tick
//   busy       : state is RUN or PEND
module baud_ctrl #(
    parameter int unsigned DIV_W       = baud_pkg::DIV_W,
    parameter int unsigned OVS         = baud_pkg::OVS,
    parameter int unsigned DEFAULT_DIV = baud_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_val,
    input  logic [3:0]       div_frac,
    input  logic             phase_clr,
    output logic             div_ack,
    output logic             tick_ovs,
    output logic             tick_bit,
    output logic             busy
);

    localparam int unsigned OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

    baud_pkg::state_e state_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       frac_q;
    logic [DIV_W-1:0] shd_div_q;
    logic [3:0]       shd_frac_q;
    logic [OVS_W-1:0] ovs_q;
    logic             div_ack_q;
    logic             tick_ovs_q;
    logic             tick_bit_q;
    logic             busy_q;

    logic             run_c;
    logic             wrap_c;
    logic [DIV_W-1:0] div_clamp_c;

    // Dropping en takes effect in the same cycle so no tick can leak into IDLE.
    assign run_c       = (state_q != baud_pkg::ST_IDLE) && en;
    assign div_clamp_c = (div_val < DIV_W'(2)) ? DIV_W'(2) : div_val;

    baud_prescale #(
        .DIV_W (DIV_W)
    ) u_prescale (
        .clk      (clk),
        .reset    (reset),
        .run_i    (run_c),
        .clr_i    (phase_clr),
        .div_i    (div_q),
        .frac_i   (frac_q),
        .wrap_c_o (wrap_c)
    );

    // FSM, divisor/shadow registers, oversample counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= baud_pkg::ST_IDLE;
            div_q      <= DIV_W'(DEFAULT_DIV);
            frac_q     <= '0;
            shd_div_q  <= DIV_W'(DEFAULT_DIV);
            shd_frac_q <= '0;
            ovs_q      <= '0;
            div_ack_q  <= 1'b0;
            tick_ovs_q <= 1'b0;
            tick_bit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            div_ack_q  <= 1'b0;
            tick_ovs_q <= wrap_c;
            tick_bit_q <= wrap_c && (ovs_q == OVS_LAST);

            if (!run_c || phase_clr) begin
                ovs_q <= '0;
            end else if (wrap_c) begin
                ovs_q <= (ovs_q == OVS_LAST) ? '0 : ovs_q + OVS_W'(1);
            end

            if (!en) begin
                // Halted: writes land at once, a pending shadow is flushed.
                state_q <= baud_pkg::ST_IDLE;
                busy_q  <= 1'b0;
                if (div_wr) begin
                    div_q      <= div_clamp_c;
                    frac_q     <= div_frac;
                    shd_div_q  <= div_clamp_c;
                    shd_frac_q <= div_frac;
                    div_ack_q  <= 1'b1;
                end else if (state_q == baud_pkg::ST_PEND) begin
                    div_q     <= shd_div_q;
                    frac_q    <= shd_frac_q;
                    div_ack_q <= 1'b1;
                end
            end else begin
                busy_q <= 1'b1;
                case (state_q)
                    baud_pkg::ST_IDLE: begin
                        state_q <= baud_pkg::ST_RUN;
                        if (div_wr) begin
                            div_q      <= div_clamp_c;
                            frac_q     <= div_frac;
                            shd_div_q  <= div_clamp_c;
                            shd_frac_q <= div_frac;
                            div_ack_q  <= 1'b1;
                        end
                    end
                    baud_pkg::ST_RUN: begin
                        if (div_wr) begin
                            shd_div_q  <= div_clamp_c;
                            shd_frac_q <= div_frac;
                            state_q    <= baud_pkg::ST_PEND;
                        end
                    end
                    baud_pkg::ST_PEND: begin
                        // A write on the wrap cycle defers the apply by one period.
                        if (div_wr) begin
                            shd_div_q  <= div_clamp_c;
                            shd_frac_q <= div_frac;
                        end else if (wrap_c) begin
                            div_q     <= shd_div_q;
                            frac_q    <= shd_frac_q;
                            div_ack_q <= 1'b1;
                            state_q   <= baud_pkg::ST_RUN;
                        end
                    end
                    default: begin
                        state_q <= baud_pkg::ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign div_ack  = div_ack_q;
    assign tick_ovs = tick_ovs_q;
    assign tick_bit = tick_bit_q;
    assign busy     = busy_q;

endmodule
